// File: rtl/meta_write_arbiter_pkg.sv
// meta_write_arbiter_pkg: shared metadata widths, request struct and sizing helper.
package meta_write_arbiter_pkg;

    localparam int META_IDX_W = 6;
    localparam int META_WAYS  = 8;
    localparam int META_TAG_W = 21;
    localparam int META_COH_W = 2;

    typedef struct packed {
        logic [META_IDX_W-1:0] idx;
        logic [META_WAYS-1:0]  way_en;
        logic [META_COH_W-1:0] coh_state;
        logic [META_TAG_W-1:0] tag;
    } meta_write_req_t;

    function automatic int sel_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/meta_write_arbiter_picker.sv
// rr_priority_picker: first asserted request at or after ptr, wrapping; ptr=0 gives fixed priority.
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    localparam logic [IW:0] NW = (IW+1)'(N);

    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW:0]   sum;

    // rotate so the search always starts at bit 0, then map the offset back
    assign rot = N'({req, req} >> ptr);

    always_comb begin
        off = '0;
        for (int k = N - 1; k >= 0; k--)
            if (rot[k]) off = IW'(k);
    end

    assign sum   = {1'b0, ptr} + {1'b0, off};
    assign idx   = IW'(sum >= NW ? sum - NW : sum);
    assign grant = |req ? N'(1) << idx : '0;

endmodule

// File: rtl/meta_write_arbiter.sv
// meta_write_arbiter: N-way metadata write arbiter with a registered one-deep output slot.
module meta_write_arbiter
    import meta_write_arbiter_pkg::*;
#(
    parameter int N_IN    = 4,
    parameter int RR_MODE = 1,
    parameter int IDX_W   = META_IDX_W,
    parameter int WAYS    = META_WAYS,
    parameter int TAG_W   = META_TAG_W,
    parameter int COH_W   = META_COH_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_IN-1:0]           io_in_valid,
    output logic [N_IN-1:0]           io_in_ready,
    input  logic [N_IN*IDX_W-1:0]     io_in_bits_idx,
    input  logic [N_IN*WAYS-1:0]      io_in_bits_way_en,
    input  logic [N_IN*COH_W-1:0]     io_in_bits_data_coh_state,
    input  logic [N_IN*TAG_W-1:0]     io_in_bits_data_tag,
    input  logic                      io_out_ready,
    output logic                      io_out_valid,
    output logic [IDX_W-1:0]          io_out_bits_idx,
    output logic [WAYS-1:0]           io_out_bits_way_en,
    output logic [COH_W-1:0]          io_out_bits_data_coh_state,
    output logic [TAG_W-1:0]          io_out_bits_data_tag,
    output logic [sel_w(N_IN)-1:0]    io_out_chosen
);

    localparam int CW = sel_w(N_IN);

    logic            enable;
    logic            any;
    logic [N_IN-1:0] grant;
    logic [CW-1:0]   w;
    logic [CW-1:0]   ptr;

    logic [IDX_W-1:0] idx_a [N_IN];
    logic [WAYS-1:0]  way_a [N_IN];
    logic [COH_W-1:0] coh_a [N_IN];
    logic [TAG_W-1:0] tag_a [N_IN];

    for (genvar i = 0; i < N_IN; i++) begin : g_slice
        assign idx_a[i] = io_in_bits_idx[i*IDX_W +: IDX_W];
        assign way_a[i] = io_in_bits_way_en[i*WAYS +: WAYS];
        assign coh_a[i] = io_in_bits_data_coh_state[i*COH_W +: COH_W];
        assign tag_a[i] = io_in_bits_data_tag[i*TAG_W +: TAG_W];
    end

    rr_priority_picker #(.N(N_IN), .IW(CW)) u_pick (
        .req   (io_in_valid),
        .ptr   (RR_MODE != 0 ? ptr : CW'(0)),
        .grant (grant),
        .idx   (w)
    );

    assign enable      = ~io_out_valid | io_out_ready;
    assign any         = |io_in_valid;
    // a single requester sees the free slot directly, valid or not
    assign io_in_ready = N_IN == 1 ? {N_IN{enable}} : (enable ? grant : '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_out_valid               <= 1'b0;
            io_out_bits_idx            <= '0;
            io_out_bits_way_en         <= '0;
            io_out_bits_data_coh_state <= '0;
            io_out_bits_data_tag       <= '0;
            io_out_chosen              <= '0;
            ptr                        <= '0;
        end else if (enable) begin
            io_out_valid <= any;
            if (any) begin
                io_out_bits_idx            <= idx_a[w];
                io_out_bits_way_en         <= way_a[w];
                io_out_bits_data_coh_state <= coh_a[w];
                io_out_bits_data_tag       <= tag_a[w];
                io_out_chosen              <= w;
                if (RR_MODE != 0) ptr <= w == CW'(N_IN - 1) ? '0 : w + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_meta_write_arbiter.sv
// tb_meta_write_arbiter: four arbiter configurations on shared stimulus, checked against a queue-free behavioural model.
module tb_meta_write_arbiter;

    bit         clk = 0;
    bit         rst = 1;
    bit         ordy = 1;
    logic [3:0] vld = '0;
    int         cnt = 0;
    int         tests = 0;
    int         fails = 0;

    logic [5:0]  p_idx [4];
    logic [7:0]  p_way [4];
    logic [1:0]  p_coh [4];
    logic [20:0] p_tag [4];
    logic [23:0] b_idx;
    logic [31:0] b_way;
    logic [7:0]  b_coh;
    logic [83:0] b_tag;

    logic        o_v   [4];
    logic [5:0]  o_idx [4];
    logic [7:0]  o_way [4];
    logic [1:0]  o_coh [4];
    logic [20:0] o_tag [4];
    logic [1:0]  ch0, ch1, ch2;
    logic [0:0]  ch3;
    logic [3:0]  r0, r1;
    logic [2:0]  r2;
    logic [0:0]  r3;
    logic [3:0]  g_rdy [4];
    logic [1:0]  g_ch  [4];

    // instance 0: RR N=4, 1: fixed N=4, 2: RR N=3, 3: RR N=1
    int cfg_n  [4] = '{4, 4, 3, 1};
    bit cfg_rr [4] = '{1, 0, 1, 1};

    bit          m_ov  [4];
    int          m_ch  [4];
    int          m_ptr [4];
    logic [5:0]  m_idx [4];
    logic [7:0]  m_way [4];
    logic [1:0]  m_coh [4];
    logic [20:0] m_tag [4];

    always #5 clk = ~clk;

    always_comb begin
        b_idx = '0;
        b_way = '0;
        b_coh = '0;
        b_tag = '0;
        for (int i = 0; i < 4; i++) begin
            b_idx[i*6 +: 6]   = p_idx[i];
            b_way[i*8 +: 8]   = p_way[i];
            b_coh[i*2 +: 2]   = p_coh[i];
            b_tag[i*21 +: 21] = p_tag[i];
        end
    end

    assign g_rdy[0] = r0;
    assign g_rdy[1] = r1;
    assign g_rdy[2] = {1'b0, r2};
    assign g_rdy[3] = {3'b0, r3};
    assign g_ch[0]  = ch0;
    assign g_ch[1]  = ch1;
    assign g_ch[2]  = ch2;
    assign g_ch[3]  = {1'b0, ch3};

    meta_write_arbiter #(.N_IN(4), .RR_MODE(1)) u_rr4 (
        .clock(clk), .reset(rst), .io_in_valid(vld), .io_in_ready(r0),
        .io_in_bits_idx(b_idx), .io_in_bits_way_en(b_way),
        .io_in_bits_data_coh_state(b_coh), .io_in_bits_data_tag(b_tag),
        .io_out_ready(ordy), .io_out_valid(o_v[0]), .io_out_bits_idx(o_idx[0]),
        .io_out_bits_way_en(o_way[0]), .io_out_bits_data_coh_state(o_coh[0]),
        .io_out_bits_data_tag(o_tag[0]), .io_out_chosen(ch0));

    meta_write_arbiter #(.N_IN(4), .RR_MODE(0)) u_fix4 (
        .clock(clk), .reset(rst), .io_in_valid(vld), .io_in_ready(r1),
        .io_in_bits_idx(b_idx), .io_in_bits_way_en(b_way),
        .io_in_bits_data_coh_state(b_coh), .io_in_bits_data_tag(b_tag),
        .io_out_ready(ordy), .io_out_valid(o_v[1]), .io_out_bits_idx(o_idx[1]),
        .io_out_bits_way_en(o_way[1]), .io_out_bits_data_coh_state(o_coh[1]),
        .io_out_bits_data_tag(o_tag[1]), .io_out_chosen(ch1));

    meta_write_arbiter #(.N_IN(3), .RR_MODE(1)) u_rr3 (
        .clock(clk), .reset(rst), .io_in_valid(vld[2:0]), .io_in_ready(r2),
        .io_in_bits_idx(b_idx[17:0]), .io_in_bits_way_en(b_way[23:0]),
        .io_in_bits_data_coh_state(b_coh[5:0]), .io_in_bits_data_tag(b_tag[62:0]),
        .io_out_ready(ordy), .io_out_valid(o_v[2]), .io_out_bits_idx(o_idx[2]),
        .io_out_bits_way_en(o_way[2]), .io_out_bits_data_coh_state(o_coh[2]),
        .io_out_bits_data_tag(o_tag[2]), .io_out_chosen(ch2));

    meta_write_arbiter #(.N_IN(1), .RR_MODE(1)) u_one (
        .clock(clk), .reset(rst), .io_in_valid(vld[0:0]), .io_in_ready(r3),
        .io_in_bits_idx(b_idx[5:0]), .io_in_bits_way_en(b_way[7:0]),
        .io_in_bits_data_coh_state(b_coh[1:0]), .io_in_bits_data_tag(b_tag[20:0]),
        .io_out_ready(ordy), .io_out_valid(o_v[3]), .io_out_bits_idx(o_idx[3]),
        .io_out_bits_way_en(o_way[3]), .io_out_bits_data_coh_state(o_coh[3]),
        .io_out_bits_data_tag(o_tag[3]), .io_out_chosen(ch3));

    task automatic check(string nm, int d, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, d, got, exp, $time);
        end
    endtask

    function automatic int pick(logic [3:0] v, int p, int n);
        for (int k = 0; k < n; k++)
            if (v[(p + k) % n]) return (p + k) % n;
        return 0;
    endfunction

    task automatic setp();
        for (int i = 0; i < 4; i++) begin
            p_idx[i] = 6'(cnt * 4 + i + 1);
            p_way[i] = 8'(1 << ((cnt + i) % 8));
            p_coh[i] = 2'(cnt + i);
            p_tag[i] = 21'(cnt * 37 + i * 1001 + 5);
        end
    endtask

    task automatic step(bit r, logic [3:0] v, bit o);
        @(posedge clk);
        #1;
        rst  = r;
        vld  = v;
        ordy = o;
        setp();
        cnt++;
    endtask

    // model: outputs are the last accepted request; the slot frees when empty or drained
    always @(negedge clk) begin
        int n, w;
        bit en, an;
        logic [3:0] vm, er;
        for (int d = 0; d < 4; d++) begin
            n = cfg_n[d];
            if (rst) begin
                m_ov[d] = 0; m_ch[d] = 0; m_ptr[d] = 0;
                m_idx[d] = 0; m_way[d] = 0; m_coh[d] = 0; m_tag[d] = 0;
            end
            vm = vld & 4'((1 << n) - 1);
            en = !m_ov[d] || ordy;
            an = vm != 0;
            w  = pick(vm, cfg_rr[d] ? m_ptr[d] : 0, n);
            er = n == 1 ? {3'b0, en} : (en && an) ? 4'(1 << w) : 4'b0;
            check("out_valid", d, 32'(o_v[d]), 32'(m_ov[d]));
            check("chosen", d, 32'(g_ch[d]), 32'(m_ch[d]));
            check("idx", d, 32'(o_idx[d]), 32'(m_idx[d]));
            check("way_en", d, 32'(o_way[d]), 32'(m_way[d]));
            check("coh", d, 32'(o_coh[d]), 32'(m_coh[d]));
            check("tag", d, 32'(o_tag[d]), 32'(m_tag[d]));
            check("in_ready", d, 32'(g_rdy[d]), 32'(er));
            if (!rst && en) begin
                m_ov[d] = an;
                if (an) begin
                    m_ch[d]  = w;
                    m_idx[d] = p_idx[w];
                    m_way[d] = p_way[w];
                    m_coh[d] = p_coh[w];
                    m_tag[d] = p_tag[w];
                    if (cfg_rr[d]) m_ptr[d] = (w + 1) % n;
                end
            end
        end
    end

    initial begin
        bit [5:0] seq1;
        bit prev;
        setp();
        step(1, 4'h0, 1);
        step(1, 4'h0, 1);
        @(negedge clk);
        check("rst_valid", 0, 32'(o_v[0]), 0);
        check("rst_chosen", 0, 32'(g_ch[0]), 0);
        check("rst_tag", 1, 32'(o_tag[1]), 0);
        // fixed priority: lowest valid index wins
        step(0, 4'b1010, 1);
        @(negedge clk);
        check("fixed_ready", 1, 32'(r1), 32'b0010);
        step(0, 4'h0, 1);
        @(negedge clk);
        check("fixed_valid", 1, 32'(o_v[1]), 1);
        check("fixed_chosen", 1, 32'(g_ch[1]), 1);
        // round robin with every requester valid
        step(1, 4'h0, 1);
        for (int i = 0; i < 6; i++) begin
            step(0, 4'hF, 1);
            @(negedge clk);
            if (i > 0) check("rr_seq", 0, 32'(g_ch[0]), 32'((i - 1) % 4));
        end
        // backpressure holds the slot
        step(0, 4'b0001, 1);
        p_idx[0] = 6'h2A;
        for (int i = 0; i < 5; i++) begin
            step(0, 4'hF, 0);
            @(negedge clk);
            check("hold_idx", 0, 32'(o_idx[0]), 32'h2A);
            check("hold_chosen", 0, 32'(g_ch[0]), 0);
            check("hold_ready", 0, 32'(r0), 0);
        end
        step(0, 4'hF, 1);
        @(negedge clk);
        check("release_ready", 0, 32'(r0), 32'b0010);
        step(0, 4'h0, 1);
        @(negedge clk);
        check("release_chosen", 0, 32'(g_ch[0]), 1);
        check("release_valid", 0, 32'(o_v[0]), 1);
        // N=3 pointer wraps from 2 back to 0
        step(1, 4'h0, 1);
        step(0, 4'b0100, 1);
        step(0, 4'b0111, 1);
        @(negedge clk);
        check("wrap_first", 2, 32'(g_ch[2]), 2);
        step(0, 4'h0, 1);
        @(negedge clk);
        check("wrap_second", 2, 32'(g_ch[2]), 0);
        // asynchronous reset drops a held output
        step(0, 4'hF, 1);
        for (int i = 0; i < 4; i++) p_tag[i] = 21'h1FFFFF;
        step(0, 4'hF, 0);
        @(negedge clk);
        check("pre_rst_tag", 0, 32'(o_tag[0]), 32'h1FFFFF);
        check("pre_rst_valid", 0, 32'(o_v[0]), 1);
        step(1, 4'hF, 0);
        @(negedge clk);
        check("async_valid", 0, 32'(o_v[0]), 0);
        check("async_tag", 0, 32'(o_tag[0]), 0);
        step(0, 4'hF, 1);
        step(0, 4'hF, 1);
        @(negedge clk);
        check("post_rst_chosen", 0, 32'(g_ch[0]), 0);
        check("post_rst_valid", 0, 32'(o_v[0]), 1);
        // single requester: out_valid trails valid by one cycle
        seq1 = 6'b001101;
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            step(0, {3'b0, seq1[k]}, 1);
            @(negedge clk);
            if (k > 0) check("one_follow", 3, 32'(o_v[3]), 32'(prev));
            check("one_chosen", 3, 32'(ch3), 0);
            prev = seq1[k];
        end
        repeat (40) step(0, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
        step(0, 4'h0, 1);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/meta_write_arbiter.md
META_WRITE_ARBITER -- requirements
Module: meta_write_arbiter

Interface
REQ-001 SHALL have parameter N_IN, default 4, number of requesters (1..16).
REQ-002 SHALL have parameter RR_MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-003 SHALL have parameters IDX_W=6, WAYS=8, TAG_W=21, COH_W=2, the metadata field widths.
REQ-004 clock  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 io_in_valid  input  N_IN  per-requester valid.
REQ-007 io_in_ready  output  N_IN  per-requester ready.
REQ-008 io_in_bits_idx / _way_en / _data_coh_state / _data_tag  input  N_IN x (IDX_W / WAYS / COH_W / TAG_W)  per-requester payload, packed, requester i in slice i.
REQ-009 io_out_ready  input  1  downstream ready.
REQ-010 io_out_valid  output  1  registered output valid.
REQ-011 io_out_bits_idx / _way_en / _data_coh_state / _data_tag  output  IDX_W / WAYS / COH_W / TAG_W  registered payload.
REQ-012 io_out_chosen  output  max(1,clog2(N_IN))  index of requester whose payload is on the output.

Function
REQ-013 SHALL define enable = ~out_valid_q | io_out_ready; a slot is free this cycle when enable=1.
REQ-014 SHALL select one winner w among asserted io_in_valid each cycle, combinationally.
REQ-015 Fixed mode: w = lowest asserted index.
REQ-016 RR mode: w = first asserted index searching ptr, ptr+1, ..., wrapping modulo N_IN.
REQ-017 io_in_ready[i] SHALL be enable & (any valid) & (i == w); at most one bit set; ready of a non-winner is 0 even if valid.
REQ-018 On accept (io_in_valid[w] & io_in_ready[w]) SHALL load payload of w and w into output registers and set out_valid_q=1 on the next edge: latency 1 cycle.
REQ-019 On enable with no valid input SHALL clear out_valid_q on next edge; payload registers hold.
REQ-020 When out_valid_q=1 and io_out_ready=0, output valid, payload, chosen SHALL be stable; all io_in_ready = 0.
REQ-021 Simultaneous io_out_ready=1 and new accept SHALL replace output in same edge: sustained throughput 1 transfer/cycle.
REQ-022 RR mode: on accept, ptr SHALL update to (w+1) mod N_IN; without accept ptr holds; fixed mode ptr unused, stays 0.
REQ-023 N_IN=1: ptr constant 0, io_out_chosen constant 0, io_in_ready[0] = enable.
REQ-024 Non-power-of-two N_IN: ptr wraps from N_IN-1 to 0, never reaches unused codes.
REQ-025 No combinational path from io_in_* to io_out_*; io_out_ready to io_in_ready combinational path permitted.

Reset
REQ-026 While reset=1: io_out_valid=0, payload regs=0, io_out_chosen=0, ptr=0, asynchronously.
REQ-027 Reset mid-transfer SHALL drop any held output; no accept in reset cycle counts; first post-reset RR search starts at 0.

Structure
REQ-028 Package meta_write_arbiter_pkg SHALL hold the meta_write_req_t struct (idx, way_en, coh_state, tag) and width constants.
REQ-029 Sub-module rr_priority_picker (inputs: request vector, ptr; output: one-hot grant + index) SHALL implement REQ-015/016, fixed mode via ptr tied 0.

Verification
REQ-030 Fixed, N_IN=4: valid=4'b1010, out_ready=1 -> ready=4'b0010, next cycle out_valid=1, chosen=1.
REQ-031 RR, N_IN=4: all valid continuously, out_ready=1 -> chosen sequence 0,1,2,3,0 on consecutive cycles.
REQ-032 Backpressure: out holds idx=0x2A, out_ready=0 for 5 cycles -> idx/chosen stable, io_in_ready=0 throughout; out_ready=1 -> next payload appears after 1 cycle.
REQ-033 RR, N_IN=3: valid only on 2 then 0 -> ptr wraps 0->0 after grant 2 (i.e. (2+1) mod 3 = 0); grant order 2,0.
REQ-034 Reset asserted while out_valid=1, tag=0x1FFFFF -> out_valid=0, tag=0 immediately; after release with all valid, chosen=0.
REQ-035 N_IN=1: valid toggling with out_ready=1 -> out_valid follows valid one cycle later, chosen=0.
